// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor. It computes Diff = A - B one bit per clock, least
//   significant bit first. The datapath is one full-subtractor cell and a
//   borrow flip-flop, so the borrow ripples through time instead of through
//   logic. A start/done handshake frames each operation.
//
//   Timing: a start accepted at edge N is followed by WIDTH SHIFT cycles, and
//   then one DONE cycle, which lies after edge N+WIDTH. A start that arrives
//   during the DONE cycle is accepted, so operations can run back to back at
//   one result every WIDTH+1 cycles.
//
// Parameters
//   WIDTH   operand and result width in bits (>= 2)
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   start   request to latch A/B and begin (honoured when not busy)
//   A       minuend, sampled only on the accepted start cycle
//   B       subtrahend, sampled only on the accepted start cycle
//   mode    (only with SERIAL_ADD_MODE_EN) 1 = add, 0 = subtract, sampled
//           with start
//   busy    high while bits are being processed
//   done    one-cycle pulse; Diff/Borrow are valid from here on
//   Diff    A - B modulo 2^WIDTH (A + B in add mode)
//   Borrow  final borrow out, 1 when A < B unsigned (carry out in add mode)
//
// Configuration macro
//   SERIAL_ADD_MODE_EN  when defined, adds the `mode` input and the add path.
//                       When undefined, the block only subtracts.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADD_MODE_EN
  input  logic             mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic             borrow_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Outputs of the single arithmetic cell for the current bit position.
  logic bit_a;
  logic bit_b;
  logic d_next;
  logic bo_next;

`ifdef SERIAL_ADD_MODE_EN
  logic mode_reg;
`endif

  always_comb begin
    bit_a  = a_sr_reg[0];
    bit_b  = b_sr_reg[0];
    // The sum bit and the difference bit are the same XOR. Only the chain bit
    // differs between adding and subtracting.
    d_next = bit_a ^ bit_b ^ borrow_reg;
`ifdef SERIAL_ADD_MODE_EN
    if (mode_reg)
      bo_next = (bit_a & bit_b) | (borrow_reg & (bit_a ^ bit_b));
    else
      bo_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_reg);
`else
    bo_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_reg);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      Diff       <= '0;
      Borrow     <= 1'b0;
`ifdef SERIAL_ADD_MODE_EN
      mode_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        // DONE accepts a new start exactly as IDLE does. Clearing done here
        // limits the done pulse to the single DONE cycle.
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr_reg   <= A;
            b_sr_reg   <= B;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
            busy       <= 1'b1;
            state_reg  <= SHIFT;
`ifdef SERIAL_ADD_MODE_EN
            mode_reg   <= mode;
`endif
          end else begin
            state_reg <= IDLE;
          end
        end

        SHIFT: begin
          // Each result bit enters at the MSB. After WIDTH shifts, the first
          // bit produced (the LSB) has reached Diff[0].
          Diff       <= {d_next, Diff[WIDTH-1:1]};
          a_sr_reg   <= a_sr_reg >> 1;
          b_sr_reg   <= b_sr_reg >> 1;
          borrow_reg <= bo_next;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_BIT) begin
            // Registered outputs are set here so that they are already valid
            // during the DONE cycle.
            state_reg <= DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
            Borrow    <= bo_next;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
